// File: rtl/ps2_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared PS/2 types, command bytes and odd-parity helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQUEST   = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } ps2_tx_state_e;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

    // Parity bit that makes the total count of ones (data + parity) odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_tx_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ps2_tx_if
// Description : Host-side load/status handshake of the PS/2 transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
interface ps2_tx_if;
    logic [7:0] data;
    logic       dataLoad;
    logic       ready;
    logic       done;
    logic       error;
    logic       rxInhibit;

    modport master (
        output data,
        output dataLoad,
        input  ready,
        input  done,
        input  error,
        input  rxInhibit
    );

    modport slave (
        input  data,
        input  dataLoad,
        output ready,
        output done,
        output error,
        output rxInhibit
    );
endinterface
`default_nettype wire

// File: rtl/ps2_line_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ps2_line_sync
// Description : 2-flop synchronizer plus falling-edge detect for one PS/2 line.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_line_sync (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic line_i,
    output logic      sync_o,
    output logic      fall_o
);

    logic [1:0] sync_q;
    logic       prev_q;

    // Reset to the idle-high level so no false edge appears after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], line_i};
            prev_q <= sync_q[1];
        end
    end

    assign sync_o = sync_q[1];
    assign fall_o = ~sync_q[1] & prev_q;

endmodule
`default_nettype wire

// File: rtl/ps2_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ps2_tx
// Description : PS/2 host-to-device command transmitter (active-low pull outputs).
//               Define PS2_TX_ACK_CHECK_EN to flag a missing device ack as error.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int counterBits = 16,
    parameter int inhibitClk  = 480,
    parameter int requestClk  = 8,
    parameter int waitTimeout = 60000
) (
    input  wire logic  clk,
    input  wire logic  reset,
    input  wire logic  ps2ClkIn,
    input  wire logic  ps2DataIn,
    output logic       ps2ClkOutLow,
    output logic       ps2DataOutLow,
    ps2_tx_if.slave    host
);

    localparam logic [counterBits-1:0] c_INHIBIT_LAST = counterBits'(inhibitClk - 1);
    localparam logic [counterBits-1:0] c_REQUEST_LAST = counterBits'(requestClk - 1);
    localparam logic [counterBits-1:0] c_TIMEOUT_LAST = counterBits'(waitTimeout - 1);
    localparam logic [3:0]             c_ACK_BIT      = 4'd10;

    logic w_clk_sync;
    logic w_clk_fall;
    logic w_data_sync;
    logic w_unused_data_fall;

    ps2_line_sync u_clk_sync (
        .clk    (clk),
        .reset  (reset),
        .line_i (ps2ClkIn),
        .sync_o (w_clk_sync),
        .fall_o (w_clk_fall)
    );

    ps2_line_sync u_data_sync (
        .clk    (clk),
        .reset  (reset),
        .line_i (ps2DataIn),
        .sync_o (w_data_sync),
        .fall_o (w_unused_data_fall)
    );

    ps2_tx_state_e          state_q, state_d;
    logic [counterBits-1:0] cnt_q, cnt_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   data_low_q, data_low_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_low_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_low_q <= data_low_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        data_low_d    = data_low_q;
        done_d        = 1'b0;
        error_d       = error_q;
        ps2ClkOutLow  = 1'b0;
        ps2DataOutLow = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (host.dataLoad) begin
                    shift_d = host.data;
                    error_d = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_INHIBIT;
                end
            end

            ST_INHIBIT: begin
                ps2ClkOutLow = 1'b1;
                if (cnt_q == c_INHIBIT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_REQUEST;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_REQUEST: begin
                ps2ClkOutLow  = 1'b1;
                ps2DataOutLow = 1'b1;
                if (cnt_q == c_REQUEST_LAST) begin
                    cnt_d      = '0;
                    bit_cnt_d  = '0;
                    data_low_d = 1'b1;
                    state_d    = ST_SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Device owns the clock; each falling edge advances one frame bit.
            ST_SHIFT: begin
                ps2DataOutLow = data_low_q;
                if (w_clk_fall) begin
                    cnt_d = '0;
                    if (bit_cnt_q == c_ACK_BIT) begin
                        data_low_d = 1'b0;
                        state_d    = ST_ACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q < 4'd8) begin
                            data_low_d = ~shift_q[bit_cnt_q[2:0]];
                        end else if (bit_cnt_q == 4'd8) begin
                            data_low_d = ~odd_parity(shift_q);
                        end else begin
                            data_low_d = 1'b0;
                        end
                    end
                end else if (cnt_q == c_TIMEOUT_LAST) begin
                    data_low_d = 1'b0;
                    error_d    = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_ACK: begin
                cnt_d   = '0;
`ifdef PS2_TX_ACK_CHECK_EN
                if (w_data_sync) begin
                    error_d = 1'b1;
                end
`endif
                state_d = ST_WAIT_IDLE;
            end

            ST_WAIT_IDLE: begin
                if (w_clk_sync && w_data_sync) begin
                    done_d  = ~error_q;
                    state_d = ST_IDLE;
                end else if (w_clk_fall) begin
                    cnt_d = '0;
                end else if (cnt_q == c_TIMEOUT_LAST) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign host.ready     = (state_q == ST_IDLE);
    assign host.rxInhibit = (state_q != ST_IDLE);
    assign host.done      = done_q;
    assign host.error     = error_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ps2_tx
// Description : Directed self-checking bench for ps2_tx with a PS/2 device model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_tx;

    localparam int c_INH  = 20;
    localparam int c_REQ  = 4;
    localparam int c_TO   = 200;
    localparam int c_HALF = 10;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic dev_clk  = 1'b1;
    logic dev_data = 1'b1;
    logic ps2ClkOutLow;
    logic ps2DataOutLow;
    logic w_clk_line;
    logic w_data_line;

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_done = 0;

    always #5 clk = ~clk;

    // Open-drain wired-AND of host pulls and device drive.
    assign w_clk_line  = ~ps2ClkOutLow  & dev_clk;
    assign w_data_line = ~ps2DataOutLow & dev_data;

    ps2_tx_if bus ();

    ps2_tx #(
        .counterBits (16),
        .inhibitClk  (c_INH),
        .requestClk  (c_REQ),
        .waitTimeout (c_TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ps2ClkIn      (w_clk_line),
        .ps2DataIn     (w_data_line),
        .ps2ClkOutLow  (ps2ClkOutLow),
        .ps2DataOutLow (ps2DataOutLow),
        .host          (bus)
    );

    always @(negedge clk) begin
        if (bus.done) n_done <= n_done + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_byte(input logic [7:0] b);
        @(negedge clk);
        bus.data     = b;
        bus.dataLoad = 1'b1;
        @(negedge clk);
        bus.dataLoad = 1'b0;
    endtask

    task automatic wait_release();
        int n;
        n = 0;
        while (!(!ps2ClkOutLow && ps2DataOutLow) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("release_seen", {31'd0, (!ps2ClkOutLow && ps2DataOutLow)}, 32'd1);
    endtask

    task automatic dev_frame(input logic [7:0] b, input logic ack_val,
                             input logic exp_done, output logic [9:0] bits);
        repeat (c_HALF) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            dev_clk = 1'b0;
            if (k == 0) begin
                repeat (2) @(negedge clk);
                check("d0_hold", {31'd0, ps2DataOutLow}, 32'd1);
                @(negedge clk);
                check("d0_at3", {31'd0, ps2DataOutLow}, {31'd0, ~b[0]});
                repeat (c_HALF - 3) @(negedge clk);
            end else begin
                repeat (c_HALF) @(negedge clk);
            end
            bits[k] = w_data_line;
            dev_clk = 1'b1;
            repeat (c_HALF) @(negedge clk);
        end
        dev_data = ack_val;
        repeat (2) @(negedge clk);
        dev_clk = 1'b0;
        repeat (c_HALF) @(negedge clk);
        check("ack_released", {31'd0, ps2DataOutLow}, 32'd0);
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (2) @(negedge clk);
        check("done_early", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        check("done_at3", {31'd0, bus.done}, {31'd0, exp_done});
        check("ready_back", {31'd0, bus.ready}, 32'd1);
    endtask

    task automatic run_byte(input logic [7:0] b, input logic par, input logic ack_val,
                            input logic exp_done, input logic exp_err, input bit timing);
        logic [9:0] bits;
        int         d0;
        d0 = n_done;
        load_byte(b);
        check("err_cleared", {31'd0, bus.error}, 32'd0);
        if (timing) begin
            check("ready_c1", {31'd0, bus.ready}, 32'd0);
            check("clklow_c1", {31'd0, ps2ClkOutLow}, 32'd1);
            check("datalow_c1", {31'd0, ps2DataOutLow}, 32'd0);
            repeat (c_INH - 1) @(negedge clk);
            check("datalow_pre", {31'd0, ps2DataOutLow}, 32'd0);
            @(negedge clk);
            check("datalow_req", {31'd0, ps2DataOutLow}, 32'd1);
            repeat (c_REQ - 1) @(negedge clk);
            check("clklow_req_end", {31'd0, ps2ClkOutLow}, 32'd1);
            @(negedge clk);
            check("clk_released", {31'd0, ps2ClkOutLow}, 32'd0);
        end
        wait_release();
        dev_frame(b, ack_val, exp_done, bits);
        check("frame_data", {24'd0, bits[7:0]}, {24'd0, b});
        check("frame_parity", {31'd0, bits[8]}, {31'd0, par});
        check("frame_stop", {31'd0, bits[9]}, 32'd1);
        check("frame_error", {31'd0, bus.error}, {31'd0, exp_err});
        repeat (5) @(negedge clk);
        check("done_count", n_done - d0, {31'd0, exp_done});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] bits_f;
        int         d0;
        bus.data     = 8'h00;
        bus.dataLoad = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_ready", {31'd0, bus.ready}, 32'd1);
        check("rst_clklow", {31'd0, ps2ClkOutLow}, 32'd0);
        check("rst_datalow", {31'd0, ps2DataOutLow}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_error", {31'd0, bus.error}, 32'd0);
        check("rst_rxinh", {31'd0, bus.rxInhibit}, 32'd0);

        // 0xED: ones=6 -> parity 1
        run_byte(8'hED, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        // 0xFF: ones=8 -> parity 1; 0x00 -> parity 1
        run_byte(8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run_byte(8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Device never clocks: error exactly c_TO cycles after release
        d0 = n_done;
        load_byte(8'hA5);
        wait_release();
        repeat (c_TO - 1) @(negedge clk);
        check("to_err_before", {31'd0, bus.error}, 32'd0);
        check("to_busy_before", {31'd0, bus.rxInhibit}, 32'd1);
        @(negedge clk);
        check("to_err", {31'd0, bus.error}, 32'd1);
        check("to_ready", {31'd0, bus.ready}, 32'd1);
        check("to_clklow", {31'd0, ps2ClkOutLow}, 32'd0);
        check("to_datalow", {31'd0, ps2DataOutLow}, 32'd0);
        repeat (5) @(negedge clk);
        check("to_no_done", n_done - d0, 32'd0);

        // Ack left high by the device
`ifdef PS2_TX_ACK_CHECK_EN
        run_byte(8'hF4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
`else
        run_byte(8'hF4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
`endif

        // dataLoad of 0x55 during SHIFT is ignored; 0x3C (ones=4 -> parity 1)
        d0 = n_done;
        load_byte(8'h3C);
        wait_release();
        fork
            dev_frame(8'h3C, 1'b0, 1'b1, bits_f);
            begin
                repeat (60) @(negedge clk);
                check("busy_ready", {31'd0, bus.ready}, 32'd0);
                bus.data     = 8'h55;
                bus.dataLoad = 1'b1;
                @(negedge clk);
                bus.dataLoad = 1'b0;
            end
        join
        check("ign_data", {24'd0, bits_f[7:0]}, 32'h3C);
        check("ign_parity", {31'd0, bits_f[8]}, 32'd1);
        repeat (5) @(negedge clk);
        check("ign_done", n_done - d0, 32'd1);

        // Reset at bitCnt 5 with d4=0 pulled low on the line
        load_byte(8'h0F);
        wait_release();
        repeat (c_HALF) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            dev_clk = 1'b0;
            repeat (c_HALF) @(negedge clk);
            dev_clk = 1'b1;
            repeat (c_HALF) @(negedge clk);
        end
        check("mid_datalow", {31'd0, ps2DataOutLow}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_clklow", {31'd0, ps2ClkOutLow}, 32'd0);
        check("mid_rst_datalow", {31'd0, ps2DataOutLow}, 32'd0);
        check("mid_rst_ready", {31'd0, bus.ready}, 32'd1);
        check("mid_rst_rxinh", {31'd0, bus.rxInhibit}, 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // 0xF4: ones=5 -> parity 0
        run_byte(8'hF4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
